trng_ctrl: RTL and testbench

Sequencer for the ring-oscillator entropy path. It powers the RO bank, holds the 32-bit RO sampler in reset through an oscillator warm-up interval, and discards the first post-warm-up words. It then captures sampler words one at a time and presents them to the PicoRV32 bus slave through a valid/request handshake, screening each word with a repetition-count health test.

---
 rtl/trng_ctrl.sv | 172 +++++++++++++++++
 tb/tb_trng_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
// trng_ctrl - ring-oscillator entropy path sequencer.
//
// Powers the RO bank, holds the 32-bit RO sampler in reset through a warm-up
// interval, and drops the first post-warm-up words. It then captures sampler
// words one at a time and presents them through a valid/request handshake.
//
// Optional feature macro: TRNG_HEALTH_EN
//   defined   - repetition-count health test and sticky FAIL state
//   undefined - no test logic; health_fail tied 0, clr_fail ignored
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            level, 1 = run entropy source
//   ro_en             RO bank enable
//   sampler_rst       sampler reset (1 = hold cleared)
//   word_in/word_valid sampler data and one-cycle strobe
//   rd_req            consume strobe from bus slave
//   rd_data/rd_valid  held random word / unconsumed-word flag
//   busy              source starting or collecting
//   health_fail       sticky health-test failure
//   clr_fail          clears failure
module trng_ctrl #(
  parameter int WARMUP_CYCLES = 1024,
  parameter int DISCARD_WORDS = 2,
  parameter int REP_LIMIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        ro_en,
  output logic        sampler_rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        rd_req,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        health_fail,
  input  logic        clr_fail
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int DW = (DISCARD_WORDS < 1) ? 1 : $clog2(DISCARD_WORDS + 1);

  typedef enum logic [2:0] {
    S_OFF, S_WARMUP, S_DISCARD, S_COLLECT, S_READY, S_FAIL
  } state_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [DW-1:0] disc_cnt;
  logic          take;
  logic          pass;

  // Outputs that are pure functions of the registered state.
  assign ro_en       = (state == S_WARMUP) || (state == S_DISCARD) ||
                       (state == S_COLLECT) || (state == S_READY);
  assign sampler_rst = (state == S_OFF) || (state == S_WARMUP) || (state == S_FAIL);
  assign busy        = (state == S_WARMUP) || (state == S_DISCARD) || (state == S_COLLECT);

  // A word is tested/captured in COLLECT, or in READY when it is being
  // consumed on the same edge. Dropping enable wins over any capture.
  assign take = word_valid && enable &&
                ((state == S_COLLECT) || ((state == S_READY) && rd_req));

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [31:0]   last_word;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;

  // rep_cnt==0 marks "no history" (first word after OFF).
  always_comb begin
    rep_next = RW'(1);
    if ((rep_cnt != '0) && (word_in == last_word))
      rep_next = rep_cnt + RW'(1);
    pass = (rep_next < RW'(REP_LIMIT));
  end
`else
  logic unused_clr_fail;
  assign unused_clr_fail = clr_fail;
  assign pass            = 1'b1;
  assign health_fail     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_OFF;
      warm_cnt    <= '0;
      disc_cnt    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
`ifdef TRNG_HEALTH_EN
      health_fail <= 1'b0;
      last_word   <= '0;
      rep_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_OFF: begin
          rd_valid <= 1'b0;
`ifdef TRNG_HEALTH_EN
          rep_cnt  <= '0;
`endif
          if (enable) begin
            state    <= S_WARMUP;
            warm_cnt <= WW'(WARMUP_CYCLES - 1);
          end
        end
        S_WARMUP: begin
          if (!enable) state <= S_OFF;
          else if (warm_cnt == '0) begin
            disc_cnt <= DW'(DISCARD_WORDS);
            state    <= (DISCARD_WORDS == 0) ? S_COLLECT : S_DISCARD;
          end else warm_cnt <= warm_cnt - WW'(1);
        end
        S_DISCARD: begin
          if (!enable) state <= S_OFF;
          else if (word_valid) begin
            disc_cnt <= disc_cnt - DW'(1);
            if (disc_cnt <= DW'(1)) state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (!enable) state <= S_OFF;
        end
        S_READY: begin
          // Plain consume; a same-edge word is handled by the capture below.
          if (!enable) begin
            state    <= S_OFF;
            rd_valid <= 1'b0;
          end else if (rd_req) begin
            state    <= S_COLLECT;
            rd_valid <= 1'b0;
          end
        end
        S_FAIL: begin
`ifdef TRNG_HEALTH_EN
          if (clr_fail) begin
            health_fail <= 1'b0;
            state       <= S_OFF;
          end
`else
          state <= S_OFF;
`endif
        end
        default: state <= S_OFF;
      endcase

      if (take) begin
        if (pass) begin
          rd_data  <= word_in;
          rd_valid <= 1'b1;
          state    <= S_READY;
`ifdef TRNG_HEALTH_EN
          last_word <= word_in;
          rep_cnt   <= rep_next;
`endif
        end else begin
          // The failing word is never presented.
          rd_valid <= 1'b0;
          state    <= S_FAIL;
`ifdef TRNG_HEALTH_EN
          health_fail <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl - directed self-checking bench for trng_ctrl
// (WARMUP_CYCLES=16, DISCARD_WORDS=2, REP_LIMIT=3).
module tb_trng_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ro_en;
  logic        sampler_rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        health_fail;
  logic        clr_fail;

  int n_chk  = 0;
  int n_fail = 0;

  trng_ctrl #(.WARMUP_CYCLES(16), .DISCARD_WORDS(2), .REP_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ro_en(ro_en),
    .sampler_rst(sampler_rst), .word_in(word_in), .word_valid(word_valid),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .health_fail(health_fail), .clr_fail(clr_fail)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
  endtask

  task automatic consume();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  // From OFF with enable already high: edge E enters WARMUP, 16 more reach DISCARD.
  task automatic startup();
    step();
    for (int i = 0; i < 16; i++) step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; word_in = '0; word_valid = 1'b0;
    rd_req = 1'b0; clr_fail = 1'b0;
    step(); step();
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_sampler_rst", 32'(sampler_rst), 32'd1);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_health_fail", 32'(health_fail), 32'd0);
    rst = 1'b0;
    step();

    // Startup
    enable = 1'b1;
    step();
    chk("start_ro_en", 32'(ro_en), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 15; i++) step();
    chk("warm_edge15_srst", 32'(sampler_rst), 32'd1);
    step();
    chk("warm_edge16_srst", 32'(sampler_rst), 32'd0);

    send(32'h0000_0001);
    chk("discard1_valid", 32'(rd_valid), 32'd0);
    send(32'h0000_0002);
    chk("discard2_valid", 32'(rd_valid), 32'd0);
    send(32'hA5A5_1234);
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_data", rd_data, 32'hA5A5_1234);

    // Handshake: held while unrequested strobes arrive
    send(32'h1111_1111);
    send(32'h2222_2222);
    chk("hold_data", rd_data, 32'hA5A5_1234);
    chk("hold_valid", 32'(rd_valid), 32'd1);
    consume();
    chk("consume_valid", 32'(rd_valid), 32'd0);
    chk("consume_busy", 32'(busy), 32'd1);
    send(32'h3333_3333);
    chk("next_data", rd_data, 32'h3333_3333);
    chk("next_valid", 32'(rd_valid), 32'd1);

    // Simultaneous consume + new word
    rd_req = 1'b1;
    send(32'hDEAD_BEEF);
    rd_req = 1'b0;
    chk("simul_valid", 32'(rd_valid), 32'd1);
    chk("simul_data", rd_data, 32'hDEAD_BEEF);

    // rd_req with nothing pending is ignored
    consume();
    consume();
    chk("idle_req_valid", 32'(rd_valid), 32'd0);
    chk("idle_req_busy", 32'(busy), 32'd1);

`ifdef TRNG_HEALTH_EN
    send(32'h0);
    chk("rep1_valid", 32'(rd_valid), 32'd1);
    consume();
    send(32'h0);
    chk("rep2_valid", 32'(rd_valid), 32'd1);
    consume();
    send(32'h0);
    chk("rep3_valid", 32'(rd_valid), 32'd0);
    chk("rep3_fail", 32'(health_fail), 32'd1);
    chk("rep3_ro_en", 32'(ro_en), 32'd0);
    chk("rep3_srst", 32'(sampler_rst), 32'd1);
    chk("rep3_busy", 32'(busy), 32'd0);
    enable = 1'b0; step();
    enable = 1'b1; step();
    chk("fail_sticky", 32'(health_fail), 32'd1);
    chk("fail_ro_en", 32'(ro_en), 32'd0);
    clr_fail = 1'b1; step(); clr_fail = 1'b0;
    chk("clr_fail_flag", 32'(health_fail), 32'd0);
    chk("clr_off_busy", 32'(busy), 32'd0);
    step();
    chk("clr_warm_busy", 32'(busy), 32'd1);
    chk("clr_warm_ro_en", 32'(ro_en), 32'd1);
`else
    for (int i = 0; i < 5; i++) begin
      send(32'h0);
      chk($sformatf("zero%0d_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("zero%0d_data", i), rd_data, 32'h0);
      chk($sformatf("zero%0d_fail", i), 32'(health_fail), 32'd0);
      consume();
    end
    clr_fail = 1'b1; step(); clr_fail = 1'b0;
    chk("clr_ignored_busy", 32'(busy), 32'd1);
`endif

    // Abort during DISCARD
    enable = 1'b0; step();
    chk("off_ro_en", 32'(ro_en), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    startup();
    chk("disc_srst", 32'(sampler_rst), 32'd0);
    send(32'h5555_5555);
    enable = 1'b0; step();
    chk("abort_ro_en", 32'(ro_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_srst", 32'(sampler_rst), 32'd1);
    chk("abort_valid", 32'(rd_valid), 32'd0);

    // Async reset while READY
    enable = 1'b1;
    startup();
    send(32'h1);
    send(32'h2);
    send(32'hCAFE_F00D);
    chk("ready_data", rd_data, 32'hCAFE_F00D);
    chk("ready_valid", 32'(rd_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", rd_data, 32'h0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_ro_en", 32'(ro_en), 32'd0);
    chk("arst_srst", 32'(sampler_rst), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
